// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-subset core: opcodes, funct codes,
// instruction-field positions and the ALU operation encoding.
package cpu_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int TGT_HI = 25;
    localparam int TGT_LO = 0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
    } alu_op_e;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
        return {{(XLEN-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: arithmetic, logic, set-less-than and shifts (shifts act on b_i).
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  alu_op_e         alu_op_i,
    input  logic [4:0]      shamt_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (alu_op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_SLL:  result_o = b_i << shamt_i;
            ALU_SRL:  result_o = b_i >> shamt_i;
            ALU_SRA:  result_o = $signed(b_i) >>> shamt_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/cpu.sv
// Single-cycle MIPS-subset core: fetch from a flat ROM bus, decode, execute and
// retire one instruction per clock. State (pc, gr, ins) is observed hierarchically.
module cpu
    import cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 10
) (
    input logic                       clock,
    input logic                       start,
    input logic [32*IMEM_WORDS-1:0]   instr
);

    localparam int IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] gr [0:NREGS-1];
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] rom [0:IMEM_WORDS-1];

    // Word 0 occupies the most significant bits of the ROM bus.
    for (genvar gi = 0; gi < IMEM_WORDS; gi++) begin : g_rom
        assign rom[gi] = instr[32*IMEM_WORDS-1-32*gi -: 32];
    end

    logic [29:0] word_idx;
    assign word_idx = pc[31:2];

    always_comb begin
        ins = '0;
        if (word_idx < 30'(IMEM_WORDS)) begin
            ins = rom[word_idx[IDX_W-1:0]];
        end
    end

    logic [5:0]      opcode;
    logic [4:0]      rs_addr;
    logic [4:0]      rt_addr;
    logic [4:0]      rd_addr;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [15:0]     imm;
    logic [25:0]     tgt;

    assign opcode  = ins[OP_HI:OP_LO];
    assign rs_addr = ins[RS_HI:RS_LO];
    assign rt_addr = ins[RT_HI:RT_LO];
    assign rd_addr = ins[RD_HI:RD_LO];
    assign shamt   = ins[SH_HI:SH_LO];
    assign funct   = ins[FN_HI:FN_LO];
    assign imm     = ins[IMM_HI:IMM_LO];
    assign tgt     = ins[TGT_HI:TGT_LO];

    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] imm_zext;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_target;

    assign rs_val    = gr[rs_addr];
    assign rt_val    = gr[rt_addr];
    assign imm_sext  = sext16(imm);
    assign imm_zext  = {{(XLEN-16){1'b0}}, imm};
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {imm_sext[XLEN-3:0], 2'b00};

    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic            wr_en;
    logic [4:0]      wr_addr;

    always_comb begin
        alu_op  = ALU_ADD;
        alu_b   = rt_val;
        wr_en   = 1'b0;
        wr_addr = rd_addr;
        pc_d    = pc_plus4;
        case (opcode)
            OP_RTYPE: begin
                wr_en = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
                    FN_SRA:          alu_op = ALU_SRA;
                    default:         wr_en  = 1'b0;
                endcase
            end
            OP_ADDI: begin
                wr_en   = 1'b1;
                wr_addr = rt_addr;
                alu_b   = imm_sext;
            end
            OP_SLTI: begin
                wr_en   = 1'b1;
                wr_addr = rt_addr;
                alu_op  = ALU_SLT;
                alu_b   = imm_sext;
            end
            OP_ANDI: begin
                wr_en   = 1'b1;
                wr_addr = rt_addr;
                alu_op  = ALU_AND;
                alu_b   = imm_zext;
            end
            OP_ORI: begin
                wr_en   = 1'b1;
                wr_addr = rt_addr;
                alu_op  = ALU_OR;
                alu_b   = imm_zext;
            end
            OP_BEQ: if (rs_val == rt_val) pc_d = br_target;
            OP_BNE: if (rs_val != rt_val) pc_d = br_target;
            OP_J:   pc_d = {pc_plus4[31:28], tgt, 2'b00};
            default: ;
        endcase
    end

    cpu_alu u_alu (
        .a_i      (rs_val),
        .b_i      (alu_b),
        .alu_op_i (alu_op),
        .shamt_i  (shamt),
        .result_o (alu_result)
    );

    // gr[0] is cleared by reset and never written, so it always reads zero.
    always_ff @(posedge clock or posedge start) begin
        if (start) begin
            pc <= '0;
            for (int i = 0; i < NREGS; i++) begin
                gr[i] <= '0;
            end
        end else begin
            pc <= pc_d;
            if (wr_en && (wr_addr != 5'd0)) begin
                gr[wr_addr] <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for the single-cycle core: expected pc/register values are queued
// per clock edge and compared against hierarchical probes after that edge.
module tb_cpu;

    localparam int W = 10;

    logic             clock = 1'b0;
    logic             start = 1'b0;
    logic [32*W-1:0]  instr = '0;

    cpu #(.IMEM_WORDS(W)) dut (
        .clock (clock),
        .start (start),
        .instr (instr)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks  = 0;
    int          errors  = 0;
    int          edge_no = 0;
    logic [31:0] prog [0:W-1];

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(logic [25:0] t);
        return {6'b000010, t};
    endfunction

    // sel 32 selects pc; 0..31 select gr[sel].
    function automatic logic [31:0] probe(int sel);
        if (sel == 32) return dut.pc;
        return dut.gr[sel];
    endfunction

    task automatic load_prog();
        for (int k = 0; k < W; k++) begin
            instr[32*W-1-32*k -: 32] = prog[k];
        end
    endtask

    task automatic default_prog(input logic [25:0] jt);
        prog[0] = enc_i(6'b001000, 0, 1, 16'd3);
        prog[1] = enc_r(1, 1, 2, 0, 6'b100000);
        prog[2] = enc_i(6'b001000, 2, 3, 16'd1);
        prog[3] = enc_r(2, 3, 4, 0, 6'b100000);
        prog[4] = enc_j(jt);
        prog[5] = enc_i(6'b001000, 1, 5, 16'd1);
        prog[6] = enc_i(6'b001000, 1, 5, 16'd3);
        prog[7] = enc_r(2, 3, 6, 0, 6'b101010);
        prog[8] = enc_r(4, 6, 7, 0, 6'b100010);
        prog[9] = 32'h0;
        load_prog();
    endtask

    task automatic push(input string n, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        edge_no++;
        $display("edge %0d start=%0b pc=%h ins=%h", edge_no, start, dut.pc, dut.ins);
    endtask

    task automatic do_reset();
        start = 1'b1;
        #2;
        start = 1'b0;
        edge_no = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] obs;
        default_prog(26'd1);
        start = 1'b1;
        #2;
        push("reset_pc", 32, 32'h0);
        push("reset_gr0", 0, 32'h0);
        push("reset_gr1", 1, 32'h0);
        push("reset_gr31", 31, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = probe(e.sel);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            end
        end
        start = 1'b0;
        edge_no = 0;
    endtask

    task automatic test_default_loop();
        exp_t e;
        logic [31:0] obs;
        logic [31:0] exp_pc [1:5];
        int          exp_reg [1:4];
        logic [31:0] exp_val [1:4];
        logic [31:0] p;
        exp_pc  = '{32'h4, 32'h8, 32'hc, 32'h10, 32'h4};
        exp_reg = '{1, 2, 3, 4};
        exp_val = '{32'h3, 32'h6, 32'h7, 32'hd};
        for (int k = 1; k <= 14; k++) begin
            if (k <= 5) begin
                push("loop_pc", 32, exp_pc[k]);
                if (k <= 4) push("loop_gr", exp_reg[k], exp_val[k]);
            end else begin
                p = (p == 32'h10) ? 32'h4 : p + 32'h4;
                push("loop_pc", 32, p);
                push("loop_gr5", 5, 32'h0);
                push("loop_gr6", 6, 32'h0);
                push("loop_gr7", 7, 32'h0);
            end
            tick();
            if (k == 5) p = 32'h4;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = probe(e.sel);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s edge %0d: got %h expected %h", e.name, k, obs, e.exp);
                end
            end
        end
        push("loop_end_gr4", 4, 32'hd);
        push("loop_end_gr2", 2, 32'h6);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = probe(e.sel);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic test_jump_forward();
        exp_t e;
        logic [31:0] obs;
        logic [31:0] exp_pc [1:11];
        int          exp_reg [1:11];
        logic [31:0] exp_val [1:11];
        exp_pc  = '{32'h4, 32'h8, 32'hc, 32'h10, 32'h14, 32'h18, 32'h1c, 32'h20, 32'h24, 32'h28, 32'h2c};
        exp_reg = '{1, 2, 3, 4, 4, 5, 5, 6, 7, 7, 7};
        exp_val = '{32'h3, 32'h6, 32'h7, 32'hd, 32'hd, 32'h4, 32'h6, 32'h1, 32'hc, 32'hc, 32'hc};
        default_prog(26'd5);
        do_reset();
        for (int k = 1; k <= 11; k++) begin
            push("jump_pc", 32, exp_pc[k]);
            push("jump_gr", exp_reg[k], exp_val[k]);
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = probe(e.sel);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s edge %0d: got %h expected %h", e.name, k, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_midrun_reset();
        exp_t e;
        logic [31:0] obs;
        default_prog(26'd1);
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        #3;
        start = 1'b1;
        #1;
        push("async_pc", 32, 32'h0);
        for (int r = 1; r <= 4; r++) push("async_gr", r, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = probe(e.sel);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            end
        end
        push("held_pc", 32, 32'h0);
        push("held_gr1", 1, 32'h0);
        tick();
        start = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = probe(e.sel);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            end
        end
        push("restart_pc", 32, 32'h4);
        push("restart_gr1", 1, 32'h3);
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = probe(e.sel);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic test_compare_branch();
        exp_t e;
        logic [31:0] obs;
        logic [31:0] exp_pc [1:8];
        int          exp_reg [1:8];
        logic [31:0] exp_val [1:8];
        prog[0] = enc_i(6'b001000, 0, 0, 16'd5);
        prog[1] = enc_i(6'b001000, 0, 1, 16'hFFFF);
        prog[2] = enc_r(1, 0, 2, 0, 6'b101010);
        prog[3] = enc_r(1, 0, 2, 0, 6'b101011);
        prog[4] = enc_i(6'b000101, 0, 0, 16'hFFFF);
        prog[5] = enc_i(6'b000100, 0, 0, 16'hFFFF);
        prog[6] = 32'h0;
        prog[7] = 32'h0;
        prog[8] = 32'h0;
        prog[9] = 32'h0;
        load_prog();
        do_reset();
        exp_pc  = '{32'h4, 32'h8, 32'hc, 32'h10, 32'h14, 32'h14, 32'h14, 32'h14};
        exp_reg = '{0, 1, 2, 2, 2, 1, 1, 0};
        exp_val = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        for (int k = 1; k <= 8; k++) begin
            push("cmpbr_pc", 32, exp_pc[k]);
            push("cmpbr_gr", exp_reg[k], exp_val[k]);
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = probe(e.sel);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s edge %0d: got %h expected %h", e.name, k, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_alu_ops();
        exp_t e;
        logic [31:0] obs;
        int          exp_reg [1:10];
        logic [31:0] exp_val [1:10];
        prog[0] = enc_i(6'b001000, 0, 1, 16'hFFF0);
        prog[1] = enc_i(6'b001101, 0, 2, 16'h00F5);
        prog[2] = enc_r(1, 2, 3, 0, 6'b100100);
        prog[3] = enc_r(1, 2, 4, 0, 6'b100111);
        prog[4] = enc_r(0, 1, 5, 4, 6'b000011);
        prog[5] = enc_r(0, 1, 6, 4, 6'b000010);
        prog[6] = enc_r(0, 2, 7, 8, 6'b000000);
        prog[7] = enc_r(2, 1, 8, 0, 6'b100011);
        prog[8] = enc_i(6'b001010, 1, 9, 16'hFFF1);
        prog[9] = enc_i(6'b001100, 1, 10, 16'hFFFF);
        load_prog();
        do_reset();
        exp_reg = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        exp_val = '{32'hFFFFFFF0, 32'h000000F5, 32'h000000F0, 32'h0000000A, 32'hFFFFFFFF,
                    32'h0FFFFFFF, 32'h0000F500, 32'h00000105, 32'h00000001, 32'h0000FFF0};
        for (int k = 1; k <= 10; k++) begin
            push("alu_pc", 32, 32'(4 * k));
            push("alu_gr", exp_reg[k], exp_val[k]);
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = probe(e.sel);
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s edge %0d: got %h expected %h", e.name, k, obs, e.exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_loop();
        test_jump_forward();
        test_midrun_reset();
        test_compare_branch();
        test_alu_ops();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
